// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter: two-requester (CSR, controller engine) arbiter for the
// single-port DAT RAM with 1-cycle read latency.
// Build option: define I3C_DAT_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (ctl first) with CSR starvation promotion.
module dat_mem_arbiter #(
  parameter int unsigned DatAw   = 7,
  parameter int unsigned DatW    = 64,
  parameter int unsigned MaxWait = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             csr_req_i,
  input  logic             csr_write_i,
  input  logic [DatAw-1:0] csr_addr_i,
  input  logic [DatW-1:0]  csr_wdata_i,
  input  logic [DatW-1:0]  csr_wmask_i,
  output logic             csr_gnt_o,
  output logic             csr_rvalid_o,
  output logic [DatW-1:0]  csr_rdata_o,

  input  logic             ctl_req_i,
  input  logic             ctl_write_i,
  input  logic [DatAw-1:0] ctl_addr_i,
  input  logic [DatW-1:0]  ctl_wdata_i,
  input  logic [DatW-1:0]  ctl_wmask_i,
  output logic             ctl_gnt_o,
  output logic             ctl_rvalid_o,
  output logic [DatW-1:0]  ctl_rdata_o,
  input  logic             ctl_lock_i,

  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [DatAw-1:0] mem_addr_o,
  output logic [DatW-1:0]  mem_wdata_o,
  output logic [DatW-1:0]  mem_wmask_o,
  input  logic [DatW-1:0]  mem_rdata_i
);

  // r_owned: engine was granted last cycle, or held the lock through an idle cycle.
  logic r_owned;
  logic r_rd_pend;
  logic r_rd_own;   // 1: response belongs to ctl, 0: to csr
`ifdef I3C_DAT_ARB_RR_EN
  logic r_last_ctl; // last winner, 0 = csr
`else
  logic [3:0] r_wait;
`endif

  logic w_lock;
  logic w_csr_wins;
  logic w_csr_gnt;
  logic w_ctl_gnt;
  logic w_mem_req;
  logic w_mem_write;

  assign w_lock = r_owned & ctl_lock_i;

`ifdef I3C_DAT_ARB_RR_EN
  assign w_csr_wins = r_last_ctl;
`else
  assign w_csr_wins = (r_wait == 4'(MaxWait));
`endif

  // Grant decision: reset gating, then lock, then contention policy.
  always_comb begin
    w_csr_gnt = 1'b0;
    w_ctl_gnt = 1'b0;
    if (!rst_ni) begin
      w_csr_gnt = 1'b0;
      w_ctl_gnt = 1'b0;
    end else if (w_lock) begin
      w_ctl_gnt = ctl_req_i;
    end else if (csr_req_i && ctl_req_i) begin
      w_csr_gnt = w_csr_wins;
      w_ctl_gnt = ~w_csr_wins;
    end else begin
      w_csr_gnt = csr_req_i;
      w_ctl_gnt = ctl_req_i;
    end
  end

  assign w_mem_req   = w_csr_gnt | w_ctl_gnt;
  assign w_mem_write = w_ctl_gnt ? ctl_write_i : csr_write_i;

  assign csr_gnt_o   = w_csr_gnt;
  assign ctl_gnt_o   = w_ctl_gnt;
  assign mem_req_o   = w_mem_req;
  assign mem_write_o = w_mem_write;
  assign mem_addr_o  = w_ctl_gnt ? ctl_addr_i  : csr_addr_i;
  assign mem_wdata_o = w_ctl_gnt ? ctl_wdata_i : csr_wdata_i;
  assign mem_wmask_o = w_ctl_gnt ? ctl_wmask_i : csr_wmask_i;

  // A response cycle that coincides with reset is suppressed as well.
  assign csr_rvalid_o = rst_ni & r_rd_pend & ~r_rd_own;
  assign ctl_rvalid_o = rst_ni & r_rd_pend &  r_rd_own;
  assign csr_rdata_o  = mem_rdata_i;
  assign ctl_rdata_o  = mem_rdata_i;

  // Read tracking, lock ownership and arbitration history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_owned    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_own   <= 1'b0;
`ifdef I3C_DAT_ARB_RR_EN
      r_last_ctl <= 1'b0;
`else
      r_wait     <= 4'd0;
`endif
    end else begin
      r_owned   <= w_ctl_gnt | w_lock;
      r_rd_pend <= w_mem_req & ~w_mem_write;
      r_rd_own  <= w_ctl_gnt;
`ifdef I3C_DAT_ARB_RR_EN
      if (w_mem_req) begin
        r_last_ctl <= w_ctl_gnt;
      end
`else
      if (csr_req_i && !w_csr_gnt) begin
        if (r_wait != 4'(MaxWait)) begin
          r_wait <= r_wait + 4'd1;
        end
      end else begin
        r_wait <= 4'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed bench for dat_mem_arbiter with a behavioural masked 1-port DAT RAM.
module tb_dat_mem_arbiter;

  localparam int unsigned DatAw = 7;
  localparam int unsigned DatW  = 64;

  localparam logic [63:0] InitA1   = 64'h1111_0001_3333_0001;
  localparam logic [63:0] InitA2   = 64'h1111_0002_3333_0002;
  localparam logic [63:0] ExpA5    = 64'hDEAD_BEEF_3333_0005;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             csr_req, csr_write, ctl_req, ctl_write, ctl_lock;
  logic [DatAw-1:0] csr_addr, ctl_addr;
  logic [DatW-1:0]  csr_wdata, csr_wmask, ctl_wdata, ctl_wmask;
  logic             csr_gnt, csr_rvalid, ctl_gnt, ctl_rvalid;
  logic [DatW-1:0]  csr_rdata, ctl_rdata;
  logic             mem_req, mem_write;
  logic [DatAw-1:0] mem_addr;
  logic [DatW-1:0]  mem_wdata, mem_wmask, mem_rdata;

  logic [DatW-1:0]  mem [0:127];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dat_mem_arbiter #(.DatAw(DatAw), .DatW(DatW), .MaxWait(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .csr_req_i(csr_req), .csr_write_i(csr_write), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_wmask_i(csr_wmask), .csr_gnt_o(csr_gnt),
    .csr_rvalid_o(csr_rvalid), .csr_rdata_o(csr_rdata),
    .ctl_req_i(ctl_req), .ctl_write_i(ctl_write), .ctl_addr_i(ctl_addr),
    .ctl_wdata_i(ctl_wdata), .ctl_wmask_i(ctl_wmask), .ctl_gnt_o(ctl_gnt),
    .ctl_rvalid_o(ctl_rvalid), .ctl_rdata_o(ctl_rdata), .ctl_lock_i(ctl_lock),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
  );

  // DAT RAM model: masked write, 1-cycle read latency, contents seeded in reset.
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 128; i++)
        mem[i] <= {16'h1111, 16'(i), 16'h3333, 16'(i)};
    end else if (mem_req) begin
      if (mem_write) mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else           mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected CSR win at contention cycle i (counted from a cleared arbiter).
  function automatic logic exp_csr_wins(input int i);
`ifdef I3C_DAT_ARB_RR_EN
    return (i % 2) == 1;
`else
    return (i % 5) == 4;
`endif
  endfunction

  initial begin
    logic prev_csr;
    rst_ni = 1'b0;
    csr_req = 0; csr_write = 0; csr_addr = '0; csr_wdata = '0; csr_wmask = '0;
    ctl_req = 0; ctl_write = 0; ctl_addr = '0; ctl_wdata = '0; ctl_wmask = '0;
    ctl_lock = 0;
    mem_rdata = '0;

    // Reset: grants suppressed even with both requests high
    step(); csr_req = 1; ctl_req = 1; #1;
    chk("rst_csr_gnt", 64'(csr_gnt), 64'd0);
    chk("rst_ctl_gnt", 64'(ctl_gnt), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_rvalid",  64'({csr_rvalid, ctl_rvalid}), 64'd0);
    step(); rst_ni = 1; csr_req = 0; ctl_req = 0;

    // Masked CSR write then read of addr 5
    step(); csr_req = 1; csr_write = 1; csr_addr = 7'd5;
    csr_wdata = 64'hDEAD_BEEF_0123_4567; csr_wmask = 64'hFFFF_FFFF_0000_0000; #1;
    chk("wr_gnt",   64'(csr_gnt), 64'd1);
    chk("wr_memwr", 64'(mem_write), 64'd1);
    chk("wr_addr",  64'(mem_addr), 64'd5);
    chk("wr_mask",  mem_wmask, 64'hFFFF_FFFF_0000_0000);
    step(); csr_write = 0; #1;
    chk("rd_gnt",   64'(csr_gnt), 64'd1);
    chk("rd_memwr", 64'(mem_write), 64'd0);
    step(); csr_req = 0; #1;
    chk("rd_rvalid", 64'(csr_rvalid), 64'd1);
    chk("rd_data",   csr_rdata, ExpA5);
    chk("rd_ctl_rv", 64'(ctl_rvalid), 64'd0);
    step(); #1;
    chk("rd_rv_off", 64'(csr_rvalid), 64'd0);

    // Continuous contention: ctl reads addr 1, csr reads addr 2
    prev_csr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); csr_req = 1; csr_addr = 7'd2; ctl_req = 1; ctl_addr = 7'd1; #1;
      chk($sformatf("cont_csr_gnt[%0d]", i), 64'(csr_gnt), 64'(exp_csr_wins(i)));
      chk($sformatf("cont_ctl_gnt[%0d]", i), 64'(ctl_gnt), 64'(!exp_csr_wins(i)));
      if (i > 0) begin
        chk($sformatf("cont_csr_rv[%0d]", i), 64'(csr_rvalid), 64'(prev_csr));
        chk($sformatf("cont_ctl_rv[%0d]", i), 64'(ctl_rvalid), 64'(!prev_csr));
        chk($sformatf("cont_data[%0d]", i), prev_csr ? csr_rdata : ctl_rdata,
            prev_csr ? InitA2 : InitA1);
      end
      prev_csr = exp_csr_wins(i);
    end
    step(); csr_req = 0; ctl_req = 0;
    step();

    // Lock: 8 locked ctl reads while csr requests
    for (int i = 0; i < 8; i++) begin
      step(); ctl_req = 1; ctl_lock = 1; ctl_addr = 7'd1; csr_req = 1; csr_addr = 7'd2; #1;
      chk($sformatf("lock_ctl_gnt[%0d]", i), 64'(ctl_gnt), 64'd1);
      chk($sformatf("lock_csr_gnt[%0d]", i), 64'(csr_gnt), 64'd0);
    end
    step(); ctl_lock = 0; #1;
    chk("unlock_csr_gnt", 64'(csr_gnt), 64'd1);
    chk("unlock_ctl_gnt", 64'(ctl_gnt), 64'd0);
    step(); csr_req = 0; ctl_req = 0;
    step();

    // Interleaved reads: ctl addr 1 then csr addr 2
    step(); ctl_req = 1; ctl_addr = 7'd1; #1;
    chk("il_ctl_gnt", 64'(ctl_gnt), 64'd1);
    step(); ctl_req = 0; csr_req = 1; csr_addr = 7'd2; #1;
    chk("il_csr_gnt",  64'(csr_gnt), 64'd1);
    chk("il_ctl_rv",   64'(ctl_rvalid), 64'd1);
    chk("il_csr_rv0",  64'(csr_rvalid), 64'd0);
    chk("il_ctl_data", ctl_rdata, InitA1);
    step(); csr_req = 0; #1;
    chk("il_csr_rv",   64'(csr_rvalid), 64'd1);
    chk("il_ctl_rv0",  64'(ctl_rvalid), 64'd0);
    chk("il_csr_data", csr_rdata, InitA2);
    step();

    // Reset after a granted read, with wait history built up beforehand
    step(); csr_req = 1; csr_addr = 7'd2; ctl_req = 1; ctl_addr = 7'd1; #1;
    chk("pre_rst_ctl_gnt0", 64'(ctl_gnt), 64'd1);
    step(); #1;
    chk("pre_rst_gnt1", 64'(ctl_gnt), 64'(!exp_csr_wins(1)));
    step(); rst_ni = 0; #1;
    chk("mid_rst_gnt",    64'({csr_gnt, ctl_gnt}), 64'd0);
    chk("mid_rst_memreq", 64'(mem_req), 64'd0);
    chk("mid_rst_rvalid", 64'({csr_rvalid, ctl_rvalid}), 64'd0);
    step(); #1;
    chk("mid_rst_rvalid2", 64'({csr_rvalid, ctl_rvalid}), 64'd0);
    step(); rst_ni = 1; #1;
    chk("post_rst_rvalid", 64'({csr_rvalid, ctl_rvalid}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      chk($sformatf("post_rst_csr_gnt[%0d]", i), 64'(csr_gnt), 64'(exp_csr_wins(i)));
    end
    step(); csr_req = 0; ctl_req = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
